// File: rtl/mul_seq_ctrl_if.sv
// Bundle of control-unit handshake, operand/product and HI/LO signals
// between the control unit, the shared Booth multiplier and mul_seq_ctrl.
interface mul_seq_ctrl_if;
  logic        start;
  logic        abort;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Control unit plus multiplier side
  modport master (
    output start, abort, op_a, op_b, mul_z,
    input  mul_a, mul_b, busy, done, hi, lo
  );

  // Sequencer side
  modport slave (
    input  start, abort, op_a, op_b, mul_z,
    output mul_a, mul_b, busy, done, hi, lo
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencer for the shared 32x32 signed Booth multiplier.
// Latches operands on start, holds them on the multiplier inputs for
// SETTLE_CYCLES clocks (multicycle path), captures the 64-bit product into
// HI/LO and pulses done for one cycle.
// Optional build macro MUL_ZERO_SKIP_EN: a zero operand bypasses the settle
// wait and produces a zero result in the cycle after the start edge.
module mul_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic          clk,
  input  logic          clr,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_mul_a;
  logic [31:0] w_mul_a_nxt;
  logic [31:0] r_mul_b;
  logic [31:0] w_mul_b_nxt;
  logic [31:0] r_hi;
  logic [31:0] w_hi_nxt;
  logic [31:0] r_lo;
  logic [31:0] w_lo_nxt;
  logic        r_busy;
  logic        r_done;

`ifdef MUL_ZERO_SKIP_EN
  logic w_zero_op;
  assign w_zero_op = (bus.op_a == 32'd0) || (bus.op_b == 32'd0);
`endif

  // Next-state and next-datapath decode; every register holds by default
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mul_a_nxt = r_mul_a;
    w_mul_b_nxt = r_mul_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      // DONE accepts a new start exactly like IDLE (back-to-back requests)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_mul_a_nxt = bus.op_a;
          w_mul_b_nxt = bus.op_b;
`ifdef MUL_ZERO_SKIP_EN
          if (w_zero_op) begin
            w_cnt_nxt   = 4'd0;
            w_hi_nxt    = 32'd0;
            w_lo_nxt    = 32'd0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = LP_CNT_INIT;
            w_state_nxt = S_SETTLE;
          end
`else
          w_cnt_nxt   = LP_CNT_INIT;
          w_state_nxt = S_SETTLE;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      // Operands held; abort wins over capture so a cancelled op never
      // touches HI/LO
      S_SETTLE: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_hi_nxt    = bus.mul_z[63:32];
          w_lo_nxt    = bus.mul_z[31:0];
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, operand, product and status registers; clr clears everything
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_mul_a <= 32'd0;
      r_mul_b <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mul_a <= w_mul_a_nxt;
      r_mul_b <= w_mul_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= (w_state_nxt == S_SETTLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.mul_a = r_mul_a;
  assign bus.mul_b = r_mul_b;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: table of directed multiplies, then
// hand-written back-to-back, ignored-start, abort and async-clear sequences.
module tb_mul_seq_ctrl;

  localparam int SC = 2;
`ifdef MUL_ZERO_SKIP_EN
  localparam int ZLAT  = 0;
  localparam int ZBUSY = 0;
`else
  localparam int ZLAT  = SC;
  localparam int ZBUSY = SC;
`endif

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  mul_seq_ctrl_if ifc();

  mul_seq_ctrl #(.SETTLE_CYCLES(SC)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc.slave)
  );

  // Behavioural stand-in for the combinational signed multiplier
  logic signed [63:0] w_a_ext;
  logic signed [63:0] w_b_ext;
  assign w_a_ext   = {{32{ifc.mul_a[31]}}, ifc.mul_a};
  assign w_b_ext   = {{32{ifc.mul_b[31]}}, ifc.mul_b};
  assign ifc.mul_z = w_a_ext * w_b_ext;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          nbusy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; n counts edges taken
  task automatic wait_done(output int n);
    n = 0;
    while (!ifc.done && n < 40) begin
      tick();
      n++;
    end
    chk("done_seen", {63'd0, ifc.done}, 64'd1);
  endtask

  // Issues one start pulse; returns edges from start edge to done and busy count
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nbusy);
    ifc.op_a  = a;
    ifc.op_b  = b;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!ifc.done && lat < 40) begin
      if (ifc.busy) nbusy++;
      tick();
      lat++;
    end
    chk("done_seen", {63'd0, ifc.done}, 64'd1);
    chk("busy_with_done", {63'd0, ifc.busy}, 64'd0);
  endtask

  initial begin
    int lat;
    int nb;
    int n;
    int extra;

    checks   = 0;
    failures = 0;
    vecs[0] = '{32'd3,          32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, SC,   SC};
    vecs[1] = '{32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, SC,   SC};
    vecs[2] = '{32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, SC,   SC};
    vecs[3] = '{32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, SC,   SC};
    vecs[4] = '{32'h12345678,   32'h00000010, 32'h00000001, 32'h23456780, SC,   SC};
    vecs[5] = '{32'h00000000,   32'h12345678, 32'h00000000, 32'h00000000, ZLAT, ZBUSY};

    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.op_a  = 32'd0;
    ifc.op_b  = 32'd0;
    clr       = 1'b1;
    tick();
    tick();
    chk("rst_busy",  {63'd0, ifc.busy}, 64'd0);
    chk("rst_done",  {63'd0, ifc.done}, 64'd0);
    chk("rst_hilo",  {ifc.hi, ifc.lo}, 64'd0);
    chk("rst_mulab", {ifc.mul_a, ifc.mul_b}, 64'd0);
    clr = 1'b0;
    tick();

    // Table-driven multiplies
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, nb);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 64'(nb), 64'(vecs[i].nbusy));
      chk($sformatf("v%0d_hi", i), {32'd0, ifc.hi}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, ifc.lo}, {32'd0, vecs[i].lo});
      tick();
      chk($sformatf("v%0d_done_one_cycle", i), {63'd0, ifc.done}, 64'd0);
    end

    // Back-to-back: start held through SETTLE and the DONE cycle
    ifc.op_a  = 32'd2;
    ifc.op_b  = 32'd3;
    ifc.start = 1'b1;
    tick();
    ifc.op_a = 32'd7;
    ifc.op_b = 32'd6;
    wait_done(n);
    chk("b2b_first_lo", {ifc.hi, ifc.lo}, 64'd6);
    chk("b2b_operand_held", {ifc.mul_a, ifc.mul_b}, {32'd2, 32'd3});
    tick();
    ifc.start = 1'b0;
    chk("b2b_rearm_busy", {63'd0, ifc.busy}, 64'd1);
    n = 1;
    while (!ifc.done && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_spacing", 64'(n), 64'(SC + 1));
    chk("b2b_second_result", {ifc.hi, ifc.lo}, 64'd42);
    tick();
    chk("b2b_back_idle", {62'd0, ifc.busy, ifc.done}, 64'd0);

    // Start pulse during SETTLE is ignored
    ifc.op_a  = 32'd4;
    ifc.op_b  = 32'd5;
    ifc.start = 1'b1;
    tick();
    ifc.op_a  = 32'd9;
    ifc.op_b  = 32'd9;
    tick();
    ifc.start = 1'b0;
    chk("ign_mul_a_held", {32'd0, ifc.mul_a}, 64'd4);
    wait_done(n);
    chk("ign_latency", 64'(n + 1), 64'(SC));
    chk("ign_result", {ifc.hi, ifc.lo}, 64'd20);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ifc.done) extra++;
    end
    chk("ign_no_extra_done", 64'(extra), 64'd0);

    // Abort in the first SETTLE cycle
    ifc.op_a  = 32'd5;
    ifc.op_b  = 32'd5;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    ifc.abort = 1'b1;
    chk("abort_in_settle", {63'd0, ifc.busy}, 64'd1);
    tick();
    ifc.abort = 1'b0;
    chk("abort_busy_low", {63'd0, ifc.busy}, 64'd0);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ifc.done) extra++;
    end
    chk("abort_no_done", 64'(extra), 64'd0);
    chk("abort_hilo_kept", {ifc.hi, ifc.lo}, 64'd20);

    // Asynchronous clear mid-SETTLE, between edges
    ifc.op_a  = 32'd9;
    ifc.op_b  = 32'd9;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("aclr_busy", {63'd0, ifc.busy}, 64'd0);
    chk("aclr_done", {63'd0, ifc.done}, 64'd0);
    chk("aclr_hilo", {ifc.hi, ifc.lo}, 64'd0);
    clr = 1'b0;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ifc.done) extra++;
    end
    chk("aclr_no_done", 64'(extra), 64'd0);
    run_op(32'd3, 32'hFFFFFFFB, lat, nb);
    chk("aclr_recover_latency", 64'(lat), 64'(SC));
    chk("aclr_recover_result", {ifc.hi, ifc.lo}, 64'hFFFFFFFF_FFFFFFF1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
